// File: rtl/load_store_buffer.sv
`default_nettype none
// ============================================================================
// load_store_buffer : in-order load/store queue with req/ack memory port and
//                     one-cycle CDB broadcast of load results
// Revision : 1.0
// ============================================================================
module load_store_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_W-1:0]          in_addr,
  input  logic                       in_is_load,
  input  logic [2:0]                 in_reg_number,
  input  logic [3:0]                 in_instruction_number,
  input  logic [DATA_W-1:0]          in_store_data,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic                       mem_ack,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       cdb_valid,
  output logic [3:0]                 cdb_instruction_number,
  output logic [2:0]                 cdb_reg_number,
  output logic [DATA_W-1:0]          cdb_value,
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int                   c_ptr_w = $clog2(DEPTH);
  localparam int                   c_cnt_w = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0]   c_full  = c_cnt_w'(DEPTH);
  localparam logic [c_ptr_w-1:0]   c_ptr_one = c_ptr_w'(1);
  localparam logic [c_cnt_w-1:0]   c_cnt_one = c_cnt_w'(1);

  // One-hot so mem_req / cdb_valid come straight off a single flop
  localparam logic [2:0] c_idle  = 3'b001;
  localparam logic [2:0] c_issue = 3'b010;
  localparam logic [2:0] c_bcast = 3'b100;

  logic [ADDR_W-1:0] r_addr_q  [DEPTH];
  logic              r_load_q  [DEPTH];
  logic [2:0]        r_reg_q   [DEPTH];
  logic [3:0]        r_instr_q [DEPTH];
  logic [DATA_W-1:0] r_data_q  [DEPTH];

  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;
  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;

  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [3:0]        r_cdb_instr;
  logic [2:0]        r_cdb_reg;
  logic [DATA_W-1:0] r_cdb_value;

  logic w_push;
  logic w_pop;
  logic w_issue;
  logic w_ack_load;

  assign in_ready   = (r_count != c_full);
  assign w_push     = in_valid && in_ready && !flush;
  assign w_issue    = (r_state == c_idle) && (r_count != '0) && !flush;
  assign w_ack_load = (r_state == c_issue) && mem_ack && !r_mem_we && !flush;
  assign w_pop      = !flush && (((r_state == c_issue) && mem_ack && r_mem_we) ||
                                 (r_state == c_bcast));

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr_q[r_tail]  <= in_addr;
      r_load_q[r_tail]  <= in_is_load;
      r_reg_q[r_tail]   <= in_reg_number;
      r_instr_q[r_tail] <= in_instruction_number;
      r_data_q[r_tail]  <= in_store_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + c_ptr_one;
      if (w_pop)  r_head <= r_head + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= c_idle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = c_idle;
    end else begin
      case (r_state)
        c_idle:  if (r_count != '0) w_state_nxt = c_issue;
        c_issue: if (mem_ack) w_state_nxt = r_mem_we ? c_idle : c_bcast;
        c_bcast: w_state_nxt = c_idle;
        default: w_state_nxt = c_idle;
      endcase
    end
  end

  always_comb begin
    mem_req   = r_state[1];
    cdb_valid = r_state[2];
  end

  // Request fields are captured once at issue and held through the wait states
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cdb_instr <= '0;
      r_cdb_reg   <= '0;
      r_cdb_value <= '0;
    end else begin
      if (w_issue) begin
        r_mem_we    <= !r_load_q[r_head];
        r_mem_addr  <= r_addr_q[r_head];
        r_mem_wdata <= r_data_q[r_head];
      end
      if (w_ack_load) begin
        r_cdb_instr <= r_instr_q[r_head];
        r_cdb_reg   <= r_reg_q[r_head];
        r_cdb_value <= mem_rdata;
      end
    end
  end

  assign mem_we                 = r_mem_we;
  assign mem_addr               = r_mem_addr;
  assign mem_wdata              = r_mem_wdata;
  assign cdb_instruction_number = r_cdb_instr;
  assign cdb_reg_number         = r_cdb_reg;
  assign cdb_value              = r_cdb_value;
  assign occupancy              = r_count;

endmodule
`default_nettype wire

// File: tb/tb_load_store_buffer.sv
`default_nettype none
// ============================================================================
// tb_load_store_buffer : scoreboard bench for load_store_buffer
// Revision : 1.0
// ============================================================================
module tb_load_store_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic        in_is_load;
  logic [2:0]  in_reg_number;
  logic [3:0]  in_instruction_number;
  logic [31:0] in_store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        cdb_valid;
  logic [3:0]  cdb_instruction_number;
  logic [2:0]  cdb_reg_number;
  logic [31:0] cdb_value;
  logic [2:0]  occupancy;

  load_store_buffer #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_is_load(in_is_load), .in_reg_number(in_reg_number),
    .in_instruction_number(in_instruction_number), .in_store_data(in_store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .cdb_valid(cdb_valid), .cdb_instruction_number(cdb_instruction_number),
    .cdb_reg_number(cdb_reg_number), .cdb_value(cdb_value), .occupancy(occupancy)
  );

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } mreq_t;
  typedef struct { logic [3:0] instr; logic [2:0] rn; logic [31:0] val; } cdb_t;

  mreq_t       exp_mem[$];
  cdb_t        exp_cdb[$];
  logic [31:0] mem_model [logic [31:0]];

  int checks   = 0;
  int failures = 0;

  logic hold_ack  = 1'b0;
  logic stray_ack = 1'b0;
  int   ack_delay = 0;
  int   wait_cnt  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Memory responder: acks after ack_delay extra cycles, backed by mem_model
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = stray_ack;
      if (mem_req && !hold_ack) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
        end else begin
          wait_cnt++;
        end
      end else if (!mem_req) begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor: pops scoreboard on each new request and each broadcast
  initial begin
    logic        prev_req     = 1'b0;
    logic        prev_we      = 1'b0;
    logic [31:0] prev_addr    = 32'h0;
    logic [31:0] prev_wdata   = 32'h0;
    logic        prev_cdb     = 1'b0;
    logic        prev_ackload = 1'b0;
    mreq_t       m;
    cdb_t        c;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) begin
        if (exp_mem.size() == 0) begin
          checks++; failures++;
          $display("FAIL mem_unexpected: got request addr %0h expected none", mem_addr);
        end else begin
          m = exp_mem.pop_front();
          check("mem_addr", mem_addr, m.addr);
          check("mem_we", mem_we, m.we);
          if (m.we) check("mem_wdata", mem_wdata, m.wdata);
        end
      end
      if (mem_req && prev_req) begin
        check("mem_stable_addr_we", {mem_addr, mem_we}, {prev_addr, prev_we});
        check("mem_stable_wdata", mem_wdata, prev_wdata);
      end
      if (cdb_valid) begin
        check("cdb_pulse", prev_cdb, 1'b0);
        if (exp_cdb.size() == 0) begin
          checks++; failures++;
          $display("FAIL cdb_unexpected: got instr %0h expected none", cdb_instruction_number);
        end else begin
          c = exp_cdb.pop_front();
          check("cdb_instr", cdb_instruction_number, c.instr);
          check("cdb_reg", cdb_reg_number, c.rn);
          check("cdb_value", cdb_value, c.val);
        end
      end
      check("cdb_latency", cdb_valid, prev_ackload);
      prev_req     = mem_req;
      prev_we      = mem_we;
      prev_addr    = mem_addr;
      prev_wdata   = mem_wdata;
      prev_cdb     = cdb_valid;
      prev_ackload = mem_ack && mem_req && !mem_we && rst_n;
    end
  end

  // Called at a negedge; returns at the following negedge with in_valid low
  task automatic push(input logic [31:0] a, input logic ld, input logic [2:0] rn,
                      input logic [3:0] ins, input logic [31:0] d,
                      input logic [31:0] exp_val, input logic exp_acc);
    in_valid              = 1'b1;
    in_addr               = a;
    in_is_load            = ld;
    in_reg_number         = rn;
    in_instruction_number = ins;
    in_store_data         = d;
    check("in_ready", in_ready, exp_acc);
    if (exp_acc) begin
      exp_mem.push_back(mreq_t'{a, !ld, d});
      if (ld) exp_cdb.push_back(cdb_t'{ins, rn, exp_val});
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    logic done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (occupancy == 3'd0 && !mem_req && !cdb_valid) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("drain_done", done, 1'b1);
  endtask

  initial begin
    int t;
    int req_cycles;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_addr = 32'h0; in_is_load = 1'b0;
    in_reg_number = 3'd0; in_instruction_number = 4'd0; in_store_data = 32'h0;
    mem_model[32'h100] = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) mem_model[32'h300 + 4*i] = 32'hA000_0000 + i;
    mem_model[32'h400] = 32'h0BADF00D;
    for (int i = 0; i < 10; i++) mem_model[32'h500 + 4*i] = 32'h5000_0000 + i*32'h111;
    mem_model[32'h700] = 32'h0000_0777;
    mem_model[32'h800] = 32'h0000_0888;

    repeat (3) @(negedge clk);
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_cdb_valid", cdb_valid, 1'b0);
    check("rst_occupancy", occupancy, 3'd0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_cdb_value", cdb_value, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);

    // Single load, zero-wait memory
    push(32'h100, 1'b1, 3'd3, 4'd5, 32'h0, 32'hDEADBEEF, 1'b1);
    check("t1_occ_after_push", occupancy, 3'd1);
    check("t1_req_not_yet", mem_req, 1'b0);
    @(negedge clk);
    check("t1_req_high", mem_req, 1'b1);
    @(negedge clk);
    check("t1_cdb_high", cdb_valid, 1'b1);
    check("t1_req_low", mem_req, 1'b0);
    @(negedge clk);
    check("t1_cdb_low", cdb_valid, 1'b0);
    check("t1_occ_zero", occupancy, 3'd0);

    // Store then load of the same address
    push(32'h200, 1'b0, 3'd0, 4'd6, 32'h12345678, 32'h0, 1'b1);
    push(32'h200, 1'b1, 3'd6, 4'd7, 32'h0, 32'h12345678, 1'b1);
    wait_idle(40);

    // Full buffer with memory stalled
    hold_ack = 1'b1;
    for (int i = 0; i < 5; i++)
      push(32'h300 + 4*i, 1'b1, 3'(i), 4'(8 + i), 32'h0, 32'hA000_0000 + i, i < 4);
    check("t3_occ_full", occupancy, 3'd4);
    check("t3_not_ready", in_ready, 1'b0);
    hold_ack = 1'b0;
    wait_idle(60);

    // Three memory wait states
    ack_delay = 3;
    push(32'h400, 1'b1, 3'd2, 4'd1, 32'h0, 32'h0BADF00D, 1'b1);
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (cdb_valid) break;
      if (mem_req) req_cycles++;
      @(negedge clk);
    end
    check("t4_req_cycles", req_cycles, 4);
    ack_delay = 0;
    wait_idle(20);

    // Wrap-around with pushes interleaved during draining
    ack_delay = 1;
    for (int i = 0; i < 10; i++) begin
      t = 0;
      while (!in_ready && t < 50) begin @(negedge clk); t++; end
      push(32'h500 + 4*i, 1'b1, 3'(i), 4'(i), 32'h0, 32'h5000_0000 + i*32'h111, 1'b1);
    end
    ack_delay = 0;
    wait_idle(100);

    // Flush while the head access is outstanding
    hold_ack = 1'b1;
    for (int i = 0; i < 3; i++)
      push(32'h600 + 4*i, 1'b1, 3'(i), 4'(12 + i), 32'h0, 32'h0, 1'b1);
    check("t6_req_inflight", mem_req, 1'b1);
    flush = 1'b1;
    exp_mem.delete();
    exp_cdb.delete();
    @(negedge clk);
    flush = 1'b0;
    check("t6_req_dropped", mem_req, 1'b0);
    check("t6_occ_zero", occupancy, 3'd0);
    stray_ack = 1'b1;
    repeat (2) @(negedge clk);
    stray_ack = 1'b0;
    check("t6_late_ack_req", mem_req, 1'b0);
    check("t6_late_ack_cdb", cdb_valid, 1'b0);
    hold_ack = 1'b0;
    push(32'h700, 1'b1, 3'd1, 4'd15, 32'h0, 32'h0000_0777, 1'b1);
    wait_idle(20);

    // Asynchronous reset mid-access
    hold_ack = 1'b1;
    for (int i = 0; i < 3; i++)
      push(32'h680 + 4*i, 1'b1, 3'(i), 4'(i), 32'h0, 32'h0, 1'b1);
    check("t7_req_inflight", mem_req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t7_req_async", mem_req, 1'b0);
    check("t7_occ_async", occupancy, 3'd0);
    exp_mem.delete();
    exp_cdb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    check("t7_cdb_quiet", cdb_valid, 1'b0);
    hold_ack = 1'b0;
    push(32'h800, 1'b1, 3'd4, 4'd9, 32'h0, 32'h0000_0888, 1'b1);
    wait_idle(20);

    @(negedge clk);
    check("sb_empty", exp_mem.size() + exp_cdb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_buffer.md
Name: load_store_buffer

Overview:
- In-order memory-access queue directly downstream of the address unit.
- Captures each computed effective address with its load/store flag, destination register tag, instruction number and store data into a circular FIFO.
- Issues the head entry to the data memory over a req/ack handshake.
- Broadcasts load results on the common data bus (CDB). Stores retire silently once the memory acknowledges them.

Parameters:
DEPTH, 4, number of queue entries; power of two, minimum 2
ADDR_W, 32, address width
DATA_W, 32, data width

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all entries and any in-flight access
in_valid  input  1  address-unit output is valid this cycle
in_ready  output  1  buffer can accept an entry; high when count != DEPTH
in_addr  input  ADDR_W  effective address
in_is_load  input  1  1 = load, 0 = store
in_reg_number  input  3  destination register tag (loads)
in_instruction_number  input  4  instruction tag
in_store_data  input  DATA_W  store data (ignored for loads)
mem_req  output  1  memory request, registered
mem_we  output  1  1 = write (store)
mem_addr  output  ADDR_W  request address
mem_wdata  output  DATA_W  write data
mem_ack  input  1  memory completes the request this cycle
mem_rdata  input  DATA_W  load data, valid when mem_ack is high
cdb_valid  output  1  one-cycle load-result broadcast
cdb_instruction_number  output  4  tag of the broadcast result
cdb_reg_number  output  3  destination register of the result
cdb_value  output  DATA_W  loaded value
occupancy  output  clog2(DEPTH)+1  current entry count

Behaviour:
- Reset (rst_n low, asynchronous) clears all of the following:
  - head, tail and count to 0; FSM to IDLE.
  - mem_req, mem_we, mem_addr, mem_wdata to 0.
  - cdb_valid, cdb_instruction_number, cdb_reg_number, cdb_value to 0.
  - Entry storage needs no reset.
- Push: on posedge, when in_valid && in_ready && !flush, write the entry at tail. Tail wraps modulo DEPTH; count increments.
- in_ready is combinational (count != DEPTH). There is no same-cycle bypass: a full buffer refuses a push even if a pop happens in the same cycle.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- FSM states are IDLE, ISSUE and BCAST. Transitions:
  - IDLE: if count != 0, go to ISSUE. On this transition, register mem_req=1 and load mem_we=!head.is_load, mem_addr=head.addr and mem_wdata=head.store_data.
  - ISSUE: mem_req and the other mem_* outputs are held stable until mem_ack. When mem_ack is sampled high:
    - mem_req goes to 0 at the same edge.
    - Store: pop the head and go to IDLE.
    - Load: latch mem_rdata, head.reg_number and head.instruction_number into the cdb_* registers, set cdb_valid=1 and go to BCAST.
  - BCAST: cdb_valid is high for exactly this one cycle. At the next edge, cdb_valid returns to 0, the head is popped and the FSM goes to IDLE.
  - cdb_* data registers hold their last value while cdb_valid is low.
- mem_ack outside ISSUE is ignored.
- Latency: entry pushed into an empty buffer at edge N → ISSUE with mem_req high after edge N+1. With zero-wait memory (ack in the first mem_req cycle), cdb_valid is high after edge N+2 and the entry is freed at edge N+3. Each memory wait cycle adds one cycle.
- Throughput: at most one access in flight; back-to-back entries see one IDLE cycle between accesses.
- Flush (synchronous) has priority over push and over all FSM activity:
  - Clears count and pointers, forces IDLE, drops mem_req and cdb_valid.
  - An abandoned in-flight request's ack is not expected. Any mem_ack after a flush is ignored because the FSM is in IDLE.
- Reset mid-access: identical to flush but asynchronous.
- Pointer wrap: head and tail are clog2(DEPTH) bits and wrap naturally.

Test Plan:
- Single load: push addr=0x100, is_load=1, reg=3, instr=5; memory acks on the first mem_req cycle with rdata=0xDEADBEEF → mem_req/mem_we=0/mem_addr=0x100 for one cycle; cdb_valid one cycle later with value 0xDEADBEEF, reg 3, instr 5; occupancy returns to 0.
- Store then load: store addr=0x200 data=0x12345678, then load addr=0x200 → mem_we=1 with wdata 0x12345678 first; no cdb_valid for the store; the load is issued next in order and broadcasts.
- Full buffer: push 5 entries back-to-back with memory ack held low → in_ready drops after 4; the 5th is not accepted; occupancy=4; releasing ack drains the entries in FIFO order.
- Wait states: ack delayed 3 cycles → mem_req, mem_addr and mem_we stay stable for 4 cycles; cdb_valid follows ack by exactly 1 edge.
- Wrap-around: 10 sequential loads instr 0..9 with pushes interleaved during draining → broadcasts occur in exact order 0..9 with correct values.
- Flush mid-ISSUE with 3 entries (and rst_n pulse in a separate run) → mem_req low at the next edge (immediately for reset); occupancy=0; no cdb_valid; a late mem_ack is ignored; a subsequent push works normally.
